// File: rtl/stack_memory.sv
// LIFO stack with registered TOS/NOS outputs, a registered indexed peek port,
// and sticky overflow/underflow flags. Storage grows upward from mem[0].
module stack_memory #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  input  logic [ADDR_W-1:0] peek_idx,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  tos,
  output logic [WIDTH-1:0]  nos,
  output logic [WIDTH-1:0]  peek_data,
  output logic              peek_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] OneC   = CW'(1);
  localparam logic [CW-1:0] ThreeC = CW'(3);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  tos_q, tos_d;
  logic [WIDTH-1:0]  nos_q, nos_d;
  logic [WIDTH-1:0]  peek_data_q, peek_data_d;
  logic              peek_valid_q, peek_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              is_full, is_empty;
  logic              do_push, do_pop, do_repl, ovf_evt, udf_evt;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CW-1:0]     nos_src, peek_pos;

  always_comb begin
    is_full  = (count_q == DepthC);
    is_empty = (count_q == '0);

    do_push = push & ~pop & ~is_full;
    do_pop  = pop & ~push & ~is_empty;
    do_repl = push & pop & ~is_empty;
    ovf_evt = push & ~pop & is_full;
    udf_evt = pop & is_empty;

    // Entry that becomes the new NOS after a pop sits two below the old TOS.
    nos_src  = count_q - ThreeC;
    peek_pos = count_q - OneC - {1'b0, peek_idx};

    wr_en   = reset_n & (do_push | do_repl);
    wr_addr = do_push ? count_q[ADDR_W-1:0] : (count_q[ADDR_W-1:0] - ADDR_W'(1));

    count_d = count_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    if (do_push) begin
      count_d = count_q + OneC;
      tos_d   = din;
      nos_d   = tos_q;
    end else if (do_pop) begin
      count_d = count_q - OneC;
      tos_d   = nos_q;
      nos_d   = (count_q >= ThreeC) ? mem[nos_src[ADDR_W-1:0]] : '0;
    end else if (do_repl) begin
      tos_d = din;
    end

    // Peek reads the pre-edge array, so same-edge writes are not visible.
    peek_valid_d = ({1'b0, peek_idx} < count_q);
    peek_data_d  = peek_valid_d ? mem[peek_pos[ADDR_W-1:0]] : '0;

    overflow_d  = ovf_evt | (overflow_q & ~err_clr);
    underflow_d = udf_evt | (underflow_q & ~err_clr);
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q      <= '0;
      tos_q        <= '0;
      nos_q        <= '0;
      peek_data_q  <= '0;
      peek_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      tos_q        <= tos_d;
      nos_q        <= nos_d;
      peek_data_q  <= peek_data_d;
      peek_valid_q <= peek_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign tos        = tos_q;
  assign nos        = nos_q;
  assign peek_data  = peek_data_q;
  assign peek_valid = peek_valid_q;
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == DepthC);
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_stack_memory.sv
// Bench for stack_memory (DEPTH=4): array-based reference model feeds a
// scoreboard queue, plus directed checks per scenario.
module tb_stack_memory;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset_n, push, pop, err_clr;
  logic [W-1:0]  din;
  logic [AW-1:0] peek_idx;
  logic [W-1:0]  tos, nos, peek_data;
  logic          peek_valid, empty, full, overflow, underflow;
  logic [AW:0]   count;

  stack_memory #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .push(push), .pop(pop), .din(din),
    .peek_idx(peek_idx), .err_clr(err_clr), .tos(tos), .nos(nos),
    .peek_data(peek_data), .peek_valid(peek_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] tos, nos, pd;
    logic [AW:0]  cnt;
    logic         pv, ovf, udf, full, empty;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] m_mem [D];
  int   m_cnt = 0;
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  // Drive one cycle of stimulus at the falling edge, model it, queue expectation.
  task automatic drive(input logic rst, input logic ps, input logic pp,
                       input logic [W-1:0] d, input int idx, input logic clr);
    exp_t e;
    logic ovf_n, udf_n;
    @(negedge clock);
    reset_n = rst; push = ps; pop = pp; din = d; peek_idx = AW'(idx); err_clr = clr;
    e.pd = '0;
    e.pv = 1'b0;
    if (!rst) begin
      m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      e.pv = (idx < m_cnt);
      if (e.pv) e.pd = m_mem[m_cnt-1-idx];
      ovf_n = ps && !pp && (m_cnt == D);
      udf_n = pp && (m_cnt == 0);
      if (ps && !pp && m_cnt < D) begin
        m_mem[m_cnt] = d; m_cnt++;
      end else if (pp && !ps && m_cnt > 0) begin
        m_cnt--;
      end else if (ps && pp && m_cnt > 0) begin
        m_mem[m_cnt-1] = d;
      end
      m_ovf = ovf_n || (m_ovf && !clr);
      m_udf = udf_n || (m_udf && !clr);
    end
    e.tos   = (m_cnt > 0) ? m_mem[m_cnt-1] : '0;
    e.nos   = (m_cnt > 1) ? m_mem[m_cnt-2] : '0;
    e.cnt   = (AW+1)'(m_cnt);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    e.full  = (m_cnt == D);
    e.empty = (m_cnt == 0);
    exp_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  // Scoreboard: pop the expectation for each edge and compare every output.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp += 9;
      if (tos !== e.tos) begin n_fail++; $display("FAIL sb_tos: got %0h want %0h", tos, e.tos); end
      if (nos !== e.nos) begin n_fail++; $display("FAIL sb_nos: got %0h want %0h", nos, e.nos); end
      if (peek_data !== e.pd) begin n_fail++; $display("FAIL sb_peek_data: got %0h want %0h", peek_data, e.pd); end
      if (peek_valid !== e.pv) begin n_fail++; $display("FAIL sb_peek_valid: got %b want %b", peek_valid, e.pv); end
      if (count !== e.cnt) begin n_fail++; $display("FAIL sb_count: got %0d want %0d", count, e.cnt); end
      if (overflow !== e.ovf) begin n_fail++; $display("FAIL sb_overflow: got %b want %b", overflow, e.ovf); end
      if (underflow !== e.udf) begin n_fail++; $display("FAIL sb_underflow: got %b want %b", underflow, e.udf); end
      if (full !== e.full) begin n_fail++; $display("FAIL sb_full: got %b want %b", full, e.full); end
      if (empty !== e.empty) begin n_fail++; $display("FAIL sb_empty: got %b want %b", empty, e.empty); end
    end
  end

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
    n_cmp++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_count: got %0d/%b want 0/1", count, empty);
    end
  endtask

  task automatic test_push_peek();
    drive(1'b1, 1'b1, 1'b0, 32'd42, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'd128, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'd256, 0, 1'b0);
    n_cmp++;
    if (count !== 3'd3 || tos !== 32'd256 || nos !== 32'd128) begin
      n_fail++; $display("FAIL push3: got cnt=%0d tos=%0d nos=%0d want 3/256/128", count, tos, nos);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 2, 1'b0);
    n_cmp++;
    if (peek_data !== 32'd42 || peek_valid !== 1'b1) begin
      n_fail++; $display("FAIL peek2: got %0d/%b want 42/1", peek_data, peek_valid);
    end
  endtask

  task automatic test_pop();
    drive(1'b1, 1'b0, 1'b1, '0, 0, 1'b0);
    n_cmp++;
    if (tos !== 32'd128 || nos !== 32'd42) begin
      n_fail++; $display("FAIL pop1: got tos=%0d nos=%0d want 128/42", tos, nos);
    end
    drive(1'b1, 1'b0, 1'b1, '0, 0, 1'b0);
    n_cmp++;
    if (tos !== 32'd42 || nos !== 32'd0 || count !== 3'd1) begin
      n_fail++; $display("FAIL pop2: got tos=%0d nos=%0d cnt=%0d want 42/0/1", tos, nos, count);
    end
    drive(1'b1, 1'b0, 1'b1, '0, 0, 1'b0);
    n_cmp++;
    if (count !== 3'd0 || tos !== 32'd0) begin
      n_fail++; $display("FAIL pop3: got cnt=%0d tos=%0d want 0/0", count, tos);
    end
    drive(1'b1, 1'b0, 1'b1, '0, 0, 1'b0);
    n_cmp++;
    if (underflow !== 1'b1 || count !== 3'd0) begin
      n_fail++; $display("FAIL pop_empty: got udf=%b cnt=%0d want 1/0", underflow, count);
    end
  endtask

  task automatic test_overflow_replace();
    drive(1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 1'b1, 1'b0, W'(i), 0, 1'b0);
    n_cmp++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL full4: got %b want 1", full); end
    drive(1'b1, 1'b1, 1'b0, 32'd5, 0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || tos !== 32'd4) begin
      n_fail++; $display("FAIL push_full: got ovf=%b tos=%0d want 1/4", overflow, tos);
    end
    drive(1'b1, 1'b1, 1'b1, 32'd9, 0, 1'b0);
    n_cmp++;
    if (tos !== 32'd9 || nos !== 32'd3 || count !== 3'd4 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL replace_full: got tos=%0d nos=%0d cnt=%0d ovf=%b want 9/3/4/1",
                         tos, nos, count, overflow);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 3, 1'b1);
    n_cmp++;
    if (overflow !== 1'b0 || peek_data !== 32'd1) begin
      n_fail++; $display("FAIL err_clr_ovf: got ovf=%b pd=%0d want 0/1", overflow, peek_data);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, 1'b0, '0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'd77, 0, 1'b0);
    n_cmp++;
    if (underflow !== 1'b1 || count !== 3'd0 || tos !== 32'd0) begin
      n_fail++; $display("FAIL replace_empty: got udf=%b cnt=%0d tos=%0d want 1/0/0",
                         underflow, count, tos);
    end
    drive(1'b1, 1'b0, 1'b0, '0, 0, 1'b1);
    n_cmp++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL clr_udf: got %b want 0", underflow); end
    drive(1'b1, 1'b0, 1'b1, '0, 0, 1'b1);
    n_cmp++;
    if (underflow !== 1'b1) begin n_fail++; $display("FAIL pop_with_clr: got %b want 1", underflow); end
  endtask

  task automatic test_peek_bounds();
    drive(1'b1, 1'b1, 1'b0, 32'd5, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0, 1, 1'b0);
    n_cmp++;
    if (peek_valid !== 1'b0 || peek_data !== 32'd0) begin
      n_fail++; $display("FAIL peek_oob: got %b/%0d want 0/0", peek_valid, peek_data);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd7, 0, 1'b0);
    n_cmp++;
    if (peek_data !== 32'd5 || tos !== 32'd7) begin
      n_fail++; $display("FAIL peek_read_old: got pd=%0d tos=%0d want 5/7", peek_data, tos);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
            int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1'b1, 1'b0, 32'd3, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, '0, 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'd4, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'd11, 0, 1'b0);
    n_cmp++;
    if (count !== 3'd0 || tos !== 32'd0 || nos !== 32'd0 || overflow !== 1'b0 ||
        underflow !== 1'b0 || peek_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got cnt=%0d tos=%0d nos=%0d ovf=%b udf=%b pv=%b want all 0",
                         count, tos, nos, overflow, underflow, peek_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; push = 1'b0; pop = 1'b0; din = '0; peek_idx = '0; err_clr = 1'b0;
    test_reset();
    test_push_peek();
    test_pop();
    test_overflow_replace();
    test_underflow();
    test_peek_bounds();
    test_back_to_back();
    test_reset_midstream();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_memory.md
# stack_memory

Parametrised stack storage that succeeds the fixed 1024×32 dual-read memory: a single-write LIFO array with push/pop control, registered top-of-stack (TOS) and next-of-stack (NOS) outputs, and a third indexed peek port. It sits under the stack unit datapath. The datapath takes its two ALU operands from TOS/NOS and reads deeper entries via peek. It handles pointer management, full/empty detection and error reporting internally.

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 1024, number of stack entries; any value ≥ 2.
- ADDR_W, $clog2(DEPTH), derived localparam; not overridable.
- clock  in  1  rising-edge clock; only clock domain.
- reset_n  in  1  reset, synchronous, active-low; sampled on the clock rising edge.
- push  in  1  push din this cycle.
- pop  in  1  pop top entry this cycle.
- din  in  WIDTH  data to push.
- peek_idx  in  ADDR_W  depth below top to read; 0 = TOS.
- err_clr  in  1  clears sticky error flags.
- tos  out  WIDTH  registered top entry.
- nos  out  WIDTH  registered second entry.
- peek_data  out  WIDTH  registered peek result.
- peek_valid  out  1  peek_idx was within the stack when sampled.
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- empty  out  1  count == 0 (combinational from count).
- full  out  1  count == DEPTH (combinational from count).
- overflow  out  1  sticky: push refused while full.
- underflow  out  1  sticky: pop refused while empty.

## Operation
- Storage is mem[0..DEPTH-1]; entry i holds the i-th pushed live word. TOS lives at mem[count-1]. Array contents are not reset.
- Reset (reset_n=0 at an edge): count=0, tos=0, nos=0, peek_data=0, peek_valid=0, overflow=0, underflow=0. Reset overrides all other inputs that cycle, including an operation in progress.
- All decisions use the pre-edge count:
  - Push only, not full: mem[count]<=din; tos<=din; nos<=old tos; count+1.
  - Push only, full: no state change; overflow<=1.
  - Pop only, count ≥ 1: tos<=old nos; nos<=mem[count-3] if count ≥ 3, else 0; count-1. Popping to 0 gives tos=0, nos=0.
  - Pop only, empty: no state change; underflow<=1.
  - Push+pop, count ≥ 1: replace. mem[count-1]<=din; tos<=din; nos and count unchanged. This is legal when full.
  - Push+pop, empty: no state change; underflow<=1.
  - Neither: hold.
- Invariants: tos=0 whenever count=0; nos=0 whenever count<2.
- Peek:
  - Sampled every cycle against the pre-edge state. Read-old semantics: same-edge writes are not visible.
  - If peek_idx < count: peek_data<=mem[count-1-peek_idx] and peek_valid<=1. Otherwise peek_data<=0 and peek_valid<=0.
- Errors:
  - overflow and underflow stay set until err_clr=1 at an edge.
  - If a new error occurs on the same edge as err_clr, the new error wins and its flag reads 1.
  - err_clr does not affect the other flag's new error.
- Index arithmetic is ADDR_W+1 bits unsigned. Nothing wraps: count saturates at 0 and DEPTH by refusal.

## Timing
- Single cycle per operation. tos, nos and count reflect an operation in the cycle after its edge.
- Back-to-back push/pop every cycle is supported with no bubbles.
- peek_data and peek_valid have 1-cycle latency from peek_idx and reflect pre-operation contents.
- empty and full follow count combinationally, so they have no extra latency.
- No handshake: push and pop are accepted or refused within the same edge. Refusal is visible only via the error flags.

## Test plan
- Reset then push 42, push 128, push 256 → count=3, tos=256, nos=128; peek_idx=2 the next cycle → peek_data=42, peek_valid=1.
- From the {42,128,256} state: pop, pop → after the first pop tos=128, nos=42; after the second tos=42, nos=0, count=1. A third pop → count=0, tos=0. A fourth pop → underflow=1, count stays 0.
- DEPTH=4: push 1..4 → full=1. Push 5 → overflow=1, tos=4. Push+pop with din=9 → tos=9, count=4, overflow still 1. err_clr → overflow=0.
- Push+pop on an empty stack → underflow=1, count=0, tos=0. Pop asserted together with err_clr → underflow remains 1.
- peek_idx=count (one past bottom) → peek_valid=0, peek_data=0. With peek_idx=0 on the same edge as a push of 7 over TOS=5 → peek_data=5.
- reset_n=0 mid-stream with push=1 → next cycle count=0, tos=nos=0, flags 0, peek_valid=0.
